ecc_lane_decode: RTL and testbench

Pipelined, multi-lane SECDED decoder with a valid/ready handshake, per-lane error reporting and saturating error statistics. A wide protected word is split into `NumLanes` independent Hamming lanes, each with its own extended parity bit. Each lane is decoded and corrected in parallel, and the result is registered in a single output stage. The block sits between ECC-protected memories or links and their consumers, and feeds a scrubber or a status/interrupt controller.

---
 rtl/ecc_pkg.sv | 27 ++
 rtl/ecc_lane_dec.sv | 66 ++++++
 rtl/ecc_lane_decode.sv | 133 +++++++++++++
 tb/tb_ecc_lane_decode.sv | 472 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ecc_pkg.sv
// ecc_pkg: shared definitions for the multi-lane SECDED decoder.
//   - error_class_e: per-lane decode outcome (CLEAN, PARITY, SINGLE, DOUBLE).
//   - get_parity_width(lane_width): Hamming check-bit count P, the smallest p
//     with 2^p >= lane_width + p + 1.
//   - get_cw_width(lane_width): Hamming code-word width (data + check bits),
//     excluding the extended overall-parity bit.
package ecc_pkg;

  typedef enum logic [1:0] {
    CLEAN  = 2'd0,
    PARITY = 2'd1,
    SINGLE = 2'd2,
    DOUBLE = 2'd3
  } error_class_e;

  function automatic int get_parity_width(input int lane_width);
    int p;
    p = 1;
    while ((1 << p) < lane_width + p + 1) p++;
    return p;
  endfunction

  function automatic int get_cw_width(input int lane_width);
    return lane_width + get_parity_width(lane_width);
  endfunction

endpackage

// File: rtl/ecc_lane_dec.sv
// ecc_lane_dec: purely combinational SECDED decode of one lane.
// Ports:
//   code      in  [CW:0]        encoded lane; MSB is the overall parity bit,
//                               bits [CW-1:0] are Hamming positions 1..CW
//   syndrome  out [P-1:0]       Hamming syndrome
//   data      out [LaneWidth-1:0] corrected data (non-power-of-two positions,
//                               ascending, packed LSB first)
//   err_class out error_class_e CLEAN / PARITY / SINGLE / DOUBLE
module ecc_lane_dec
  import ecc_pkg::*;
#(
  parameter int LaneWidth = 32,
  localparam int P = get_parity_width(LaneWidth),
  localparam int CW = get_cw_width(LaneWidth)
) (
  input  logic [CW:0]          code,
  output logic [P-1:0]         syndrome,
  output logic [LaneWidth-1:0] data,
  output error_class_e         err_class
);

  localparam logic [P-1:0] MaxPos = P'(CW);

  logic          par;
  logic [CW-1:0] fixed;

  // Syndrome bit i covers every position whose index has bit i set.
  always_comb begin
    syndrome = '0;
    for (int j = 1; j <= CW; j++) begin
      for (int i = 0; i < P; i++) begin
        if (((j >> i) & 1) != 0) syndrome[i] = syndrome[i] ^ code[j-1];
      end
    end
  end

  assign par = ^code;

  // A non-zero syndrome pointing past the last position cannot come from a
  // single flip, so it is treated as uncorrectable whatever the parity says.
  always_comb begin
    if (syndrome == '0) begin
      err_class = par ? PARITY : CLEAN;
    end else if (par && (syndrome <= MaxPos)) begin
      err_class = SINGLE;
    end else begin
      err_class = DOUBLE;
    end
  end

  always_comb begin
    fixed = code[CW-1:0];
    for (int j = 1; j <= CW; j++) begin
      if ((err_class == SINGLE) && (syndrome == P'(j))) fixed[j-1] = ~code[j-1];
    end
  end

  // Position j (not a power of two) holds data bit j-1-(#powers of two <= j);
  // the count of powers of two <= j is clog2(j+1).
  for (genvar j = 1; j <= CW; j++) begin : g_extract
    if ((j & (j - 1)) != 0) begin : g_data
      assign data[j - 1 - $clog2(j + 1)] = fixed[j-1];
    end
  end

endmodule

// File: rtl/ecc_lane_decode.sv
// ecc_lane_decode: pipelined multi-lane SECDED decoder with valid/ready
// handshake, per-lane error flags, saturating error counters and a sticky irq.
// Optional feature macro: ECC_LANE_DECODE_COUNTERS_EN (error counters).
// Ports:
//   clk_i, rst_ni              clock, asynchronous active-low reset
//   valid_i/ready_o/data_i     input word (lane k at [k*(CW+1) +: CW+1])
//   valid_o/ready_i            output handshake
//   data_o                     corrected data (lane k at [k*LaneWidth +: LaneWidth])
//   syndrome_o                 per-lane syndromes
//   single/parity/double_error_o per-lane flags
//   clear_i                    clears counters and irq_o
//   single_cnt_o/double_cnt_o  correctable / uncorrectable word counts
//   irq_o                      sticky uncorrectable-error flag
// Handshake: a word transfers on a cycle where valid and ready are both high;
// the output register accepts a new word whenever it is empty or being drained
// in the same cycle (ready_o = ~valid_o | ready_i), and holds all outputs
// stable while valid_o & ~ready_i.
module ecc_lane_decode
  import ecc_pkg::*;
#(
  parameter int DataWidth = 64,
  parameter int NumLanes = 2,
  parameter int CntWidth = 16,
  localparam int LaneWidth = DataWidth / NumLanes,
  localparam int P = get_parity_width(LaneWidth),
  localparam int CW = get_cw_width(LaneWidth)
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         valid_i,
  output logic                         ready_o,
  input  logic [NumLanes*(CW+1)-1:0]   data_i,
  output logic                         valid_o,
  input  logic                         ready_i,
  output logic [DataWidth-1:0]         data_o,
  output logic [NumLanes*P-1:0]        syndrome_o,
  output logic [NumLanes-1:0]          single_error_o,
  output logic [NumLanes-1:0]          parity_error_o,
  output logic [NumLanes-1:0]          double_error_o,
  input  logic                         clear_i,
  output logic [CntWidth-1:0]          single_cnt_o,
  output logic [CntWidth-1:0]          double_cnt_o,
  output logic                         irq_o
);

  logic [DataWidth-1:0]  dec_data;
  logic [NumLanes*P-1:0] dec_syn;
  logic [NumLanes-1:0]   dec_single;
  logic [NumLanes-1:0]   dec_parity;
  logic [NumLanes-1:0]   dec_double;
  logic                  uncorrectable;
  logic                  accept;

  for (genvar k = 0; k < NumLanes; k++) begin : g_lane
    error_class_e cls;

    ecc_lane_dec #(
      .LaneWidth(LaneWidth)
    ) u_dec (
      .code     (data_i[k*(CW+1) +: CW+1]),
      .syndrome (dec_syn[k*P +: P]),
      .data     (dec_data[k*LaneWidth +: LaneWidth]),
      .err_class(cls)
    );

    assign dec_single[k] = (cls == SINGLE);
    assign dec_parity[k] = (cls == PARITY);
    assign dec_double[k] = (cls == DOUBLE);
  end

  assign uncorrectable = |dec_double;
  assign ready_o       = ~valid_o | ready_i;
  assign accept        = valid_i & ready_o;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_o        <= 1'b0;
      data_o         <= '0;
      syndrome_o     <= '0;
      single_error_o <= '0;
      parity_error_o <= '0;
      double_error_o <= '0;
    end else if (accept) begin
      valid_o        <= 1'b1;
      data_o         <= dec_data;
      syndrome_o     <= dec_syn;
      single_error_o <= dec_single;
      parity_error_o <= dec_parity;
      double_error_o <= dec_double;
    end else if (ready_i) begin
      valid_o <= 1'b0;
    end
  end

  // A new uncorrectable word outranks a simultaneous clear.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      irq_o <= 1'b0;
    end else if (accept && uncorrectable) begin
      irq_o <= 1'b1;
    end else if (clear_i) begin
      irq_o <= 1'b0;
    end
  end

`ifdef ECC_LANE_DECODE_COUNTERS_EN
  logic correctable;

  assign correctable = ~uncorrectable & ((|dec_single) | (|dec_parity));

  // Clear outranks a simultaneous increment.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      single_cnt_o <= '0;
      double_cnt_o <= '0;
    end else if (clear_i) begin
      single_cnt_o <= '0;
      double_cnt_o <= '0;
    end else begin
      if (accept && correctable && (single_cnt_o != '1)) begin
        single_cnt_o <= single_cnt_o + CntWidth'(1);
      end
      if (accept && uncorrectable && (double_cnt_o != '1)) begin
        double_cnt_o <= double_cnt_o + CntWidth'(1);
      end
    end
  end
`else
  assign single_cnt_o = '0;
  assign double_cnt_o = '0;
`endif

endmodule

// File: tb/tb_ecc_lane_decode.sv
// tb_ecc_lane_decode: self-checking bench for ecc_lane_decode.
// A second instance with CntWidth=2 shares all inputs to exercise counter
// saturation. Expected values come from a position-index reference model:
// the syndrome of a lane is the XOR of the indices of its set bits.
module tb_ecc_lane_decode;

  localparam int DW = 64;
  localparam int NL = 2;
  localparam int LW = 32;
  localparam int P = 6;
  localparam int CW = 38;
  localparam int EW = CW + 1;
  localparam int IW = NL * EW;
  localparam int CNTW = 16;
  localparam int MAX16 = 65535;
  localparam int MAX2 = 3;
`ifdef ECC_LANE_DECODE_COUNTERS_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  // clock / reset
  logic clk_i = 1'b0;
  logic rst_ni;
  always #5 clk_i = ~clk_i;

  logic            valid_i, ready_i, clear_i;
  logic [IW-1:0]   data_i;
  logic            ready_o, valid_o, irq_o;
  logic [DW-1:0]   data_o;
  logic [NL*P-1:0] syndrome_o;
  logic [NL-1:0]   single_error_o, parity_error_o, double_error_o;
  logic [CNTW-1:0] single_cnt_o, double_cnt_o;

  logic            sat_ready, sat_valid, sat_irq;
  logic [DW-1:0]   sat_data;
  logic [NL*P-1:0] sat_syn;
  logic [NL-1:0]   sat_se, sat_pe, sat_de;
  logic [1:0]      sat_single_cnt, sat_double_cnt;

  ecc_lane_decode #(.DataWidth(DW), .NumLanes(NL), .CntWidth(CNTW)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .valid_i(valid_i), .ready_o(ready_o),
    .data_i(data_i), .valid_o(valid_o), .ready_i(ready_i), .data_o(data_o),
    .syndrome_o(syndrome_o), .single_error_o(single_error_o),
    .parity_error_o(parity_error_o), .double_error_o(double_error_o),
    .clear_i(clear_i), .single_cnt_o(single_cnt_o), .double_cnt_o(double_cnt_o),
    .irq_o(irq_o)
  );

  ecc_lane_decode #(.DataWidth(DW), .NumLanes(NL), .CntWidth(2)) dut_sat (
    .clk_i(clk_i), .rst_ni(rst_ni), .valid_i(valid_i), .ready_o(sat_ready),
    .data_i(data_i), .valid_o(sat_valid), .ready_i(ready_i), .data_o(sat_data),
    .syndrome_o(sat_syn), .single_error_o(sat_se), .parity_error_o(sat_pe),
    .double_error_o(sat_de), .clear_i(clear_i), .single_cnt_o(sat_single_cnt),
    .double_cnt_o(sat_double_cnt), .irq_o(sat_irq)
  );

  int n_checks = 0;
  int n_fail = 0;

  // reference model state and scoreboard
  logic [DW-1:0]   exp_q[$];
  bit              m_valid, m_irq;
  logic [DW-1:0]   m_data;
  logic [NL*P-1:0] m_syn;
  logic [NL-1:0]   m_se, m_pe, m_de;
  int              m_scnt, m_dcnt, m_scnt2, m_dcnt2;

  function automatic logic [IW-1:0] encode(input logic [DW-1:0] d);
    logic [IW-1:0] w;
    w = '0;
    for (int l = 0; l < NL; l++) begin
      logic [EW-1:0] lane;
      int k;
      int s;
      lane = '0;
      k = 0;
      s = 0;
      for (int j = 1; j <= CW; j++) begin
        if ((j & (j - 1)) != 0) begin
          lane[j-1] = d[l*LW+k];
          if (d[l*LW+k]) s = s ^ j;
          k++;
        end
      end
      for (int i = 0; i < P; i++) lane[(1 << i) - 1] = s[i];
      lane[CW] = ^lane[CW-1:0];
      w[l*EW +: EW] = lane;
    end
    return w;
  endfunction

  // pos 1..CW is a Hamming position, pos CW+1 is the overall parity bit
  function automatic logic [IW-1:0] flip(input logic [IW-1:0] w, input int lane, input int pos);
    w[lane*EW+pos-1] = ~w[lane*EW+pos-1];
    return w;
  endfunction

  function automatic void ref_decode(input logic [IW-1:0] w, output logic [DW-1:0] d,
                                     output logic [NL*P-1:0] s, output logic [NL-1:0] se,
                                     output logic [NL-1:0] pe, output logic [NL-1:0] de);
    d = '0; s = '0; se = '0; pe = '0; de = '0;
    for (int l = 0; l < NL; l++) begin
      logic [EW-1:0] lane;
      int syn;
      int k;
      lane = w[l*EW +: EW];
      syn = 0;
      k = 0;
      for (int j = 1; j <= CW; j++) if (lane[j-1]) syn = syn ^ j;
      if (syn == 0) begin
        pe[l] = ^lane;
      end else if ((^lane) && syn <= CW) begin
        se[l] = 1'b1;
        lane[syn-1] = ~lane[syn-1];
      end else begin
        de[l] = 1'b1;
      end
      s[l*P +: P] = syn[P-1:0];
      for (int j = 1; j <= CW; j++) begin
        if ((j & (j - 1)) != 0) begin
          d[l*LW+k] = lane[j-1];
          k++;
        end
      end
    end
  endfunction

  function automatic logic [IW-1:0] corrupt(input logic [IW-1:0] w);
    for (int l = 0; l < NL; l++) begin
      int kind, a, b, c;
      kind = $urandom_range(5, 0);
      a = $urandom_range(CW, 1);
      b = (a % CW) + 1;
      c = (b % CW) + 1;
      case (kind)
        2: w = flip(w, l, a);
        3: w = flip(w, l, CW + 1);
        4: w = flip(flip(w, l, a), l, b);
        5: w = flip(flip(flip(w, l, a), l, b), l, c);
        default: ;
      endcase
    end
    return w;
  endfunction

  task automatic model_reset();
    m_valid = 0; m_irq = 0; m_data = '0; m_syn = '0;
    m_se = '0; m_pe = '0; m_de = '0;
    m_scnt = 0; m_dcnt = 0; m_scnt2 = 0; m_dcnt2 = 0;
    exp_q.delete();
  endtask

  // advance one clock; the model commits its update at the edge
  task automatic tick();
    bit acc, unc, corr;
    logic [DW-1:0] d;
    logic [NL*P-1:0] s;
    logic [NL-1:0] se, pe, de;
    acc = rst_ni && valid_i && (!m_valid || ready_i);
    ref_decode(data_i, d, s, se, pe, de);
    unc = |de;
    corr = !unc && ((|se) || (|pe));
    @(posedge clk_i);
    if (rst_ni) begin
      if (acc) begin
        m_valid = 1; m_data = d; m_syn = s; m_se = se; m_pe = pe; m_de = de;
        exp_q.push_back(d);
      end else if (ready_i) begin
        m_valid = 0;
      end
      if (clear_i) begin
        m_scnt = 0; m_dcnt = 0; m_scnt2 = 0; m_dcnt2 = 0;
      end else begin
        if (acc && corr && m_scnt < MAX16) m_scnt++;
        if (acc && unc && m_dcnt < MAX16) m_dcnt++;
        if (acc && corr && m_scnt2 < MAX2) m_scnt2++;
        if (acc && unc && m_dcnt2 < MAX2) m_dcnt2++;
      end
      if (acc && unc) m_irq = 1;
      else if (clear_i) m_irq = 0;
    end
    #1;
  endtask

  // driver: return to an empty, idle pipeline
  task automatic idle();
    valid_i = 0; ready_i = 1; clear_i = 0;
    tick();
  endtask

  task automatic test_reset();
    rst_ni = 0; valid_i = 0; ready_i = 1; clear_i = 0; data_i = '0;
    model_reset();
    repeat (2) @(posedge clk_i);
    #1;
    n_checks++;
    if ({valid_o, ready_o, irq_o} !== 3'b010) begin
      n_fail++; $display("FAIL reset_hs: valid/ready/irq got %b exp 010", {valid_o, ready_o, irq_o});
    end
    n_checks++;
    if ({data_o, syndrome_o, single_error_o, parity_error_o, double_error_o} !== '0) begin
      n_fail++; $display("FAIL reset_out: got data %h syn %h flags %b%b%b exp all zero",
                         data_o, syndrome_o, single_error_o, parity_error_o, double_error_o);
    end
    n_checks++;
    if ({single_cnt_o, double_cnt_o, sat_single_cnt, sat_double_cnt} !== '0) begin
      n_fail++; $display("FAIL reset_cnt: got %0d %0d %0d %0d exp 0", single_cnt_o, double_cnt_o,
                         sat_single_cnt, sat_double_cnt);
    end
    rst_ni = 1;
    tick();
  endtask

  task automatic test_clean();
    data_i = encode(64'hDEADBEEF_01234567); valid_i = 1; ready_i = 1;
    tick();
    valid_i = 0;
    n_checks++;
    if (valid_o !== 1'b1 || data_o !== 64'hDEADBEEF_01234567) begin
      n_fail++; $display("FAIL clean_data: valid %b data %h exp 1 deadbeef01234567", valid_o, data_o);
    end
    n_checks++;
    if ({syndrome_o, single_error_o, parity_error_o, double_error_o, irq_o} !== '0) begin
      n_fail++; $display("FAIL clean_flags: syn %h flags %b%b%b irq %b exp zero", syndrome_o,
                         single_error_o, parity_error_o, double_error_o, irq_o);
    end
    n_checks++;
    if (single_cnt_o !== 16'd0 || double_cnt_o !== 16'd0) begin
      n_fail++; $display("FAIL clean_cnt: got %0d %0d exp 0 0", single_cnt_o, double_cnt_o);
    end
    idle();
  endtask

  task automatic test_single();
    logic [DW-1:0] d;
    d = {$urandom, $urandom};
    data_i = flip(encode(d), 1, 5); valid_i = 1;
    tick();
    valid_i = 0;
    n_checks++;
    if (data_o !== d) begin
      n_fail++; $display("FAIL single_data: got %h exp %h", data_o, d);
    end
    n_checks++;
    if (single_error_o !== 2'b10 || double_error_o !== 2'b00 || syndrome_o[P +: P] !== 6'd5) begin
      n_fail++; $display("FAIL single_flags: se %b de %b syn1 %0d exp 10 00 5", single_error_o,
                         double_error_o, syndrome_o[P +: P]);
    end
    n_checks++;
    if (single_cnt_o !== 16'(CNT_EN ? 1 : 0) || irq_o !== 1'b0) begin
      n_fail++; $display("FAIL single_cnt: cnt %0d irq %b exp %0d 0", single_cnt_o, irq_o, CNT_EN ? 1 : 0);
    end
    idle();
  endtask

  task automatic test_double();
    data_i = flip(flip(encode({$urandom, $urandom}), 0, 3), 0, 6); valid_i = 1;
    tick();
    n_checks++;
    if (double_error_o !== 2'b01 || single_error_o !== 2'b00 || syndrome_o[0 +: P] !== 6'd5) begin
      n_fail++; $display("FAIL double_flags: de %b se %b syn0 %0d exp 01 00 5", double_error_o,
                         single_error_o, syndrome_o[0 +: P]);
    end
    n_checks++;
    if (double_cnt_o !== 16'(CNT_EN ? 1 : 0) || irq_o !== 1'b1) begin
      n_fail++; $display("FAIL double_cnt: cnt %0d irq %b exp %0d 1", double_cnt_o, irq_o, CNT_EN ? 1 : 0);
    end
    // three flips with XOR 41 > CW: odd parity but still uncorrectable
    data_i = flip(flip(flip(encode({$urandom, $urandom}), 1, 32), 1, 8), 1, 1);
    tick();
    n_checks++;
    if (double_error_o !== 2'b10 || single_error_o !== 2'b00 || syndrome_o[P +: P] !== 6'd41 ||
        double_cnt_o !== 16'(m_dcnt * CNT_EN)) begin
      n_fail++; $display("FAIL double_range: de %b se %b syn1 %0d cnt %0d exp 10 00 41 %0d",
                         double_error_o, single_error_o, syndrome_o[P +: P], double_cnt_o, m_dcnt * CNT_EN);
    end
    clear_i = 1;
    data_i = flip(flip(encode({$urandom, $urandom}), 0, 3), 0, 6);
    tick();
    n_checks++;
    if (double_cnt_o !== 16'd0 || irq_o !== 1'b1) begin
      n_fail++; $display("FAIL clear_vs_set: cnt %0d irq %b exp 0 1", double_cnt_o, irq_o);
    end
    valid_i = 0;
    tick();
    n_checks++;
    if (irq_o !== 1'b0) begin
      n_fail++; $display("FAIL irq_clear: got %b exp 0", irq_o);
    end
    idle();
  endtask

  task automatic test_parity();
    logic [DW-1:0] d;
    d = {$urandom, $urandom};
    data_i = flip(encode(d), 0, CW + 1); valid_i = 1;
    tick();
    valid_i = 0;
    n_checks++;
    if (parity_error_o !== 2'b01 || single_error_o !== 2'b00 || double_error_o !== 2'b00 || data_o !== d) begin
      n_fail++; $display("FAIL parity_only: pe %b se %b de %b data %h exp 01 00 00 %h", parity_error_o,
                         single_error_o, double_error_o, data_o, d);
    end
    n_checks++;
    if (single_cnt_o !== 16'(m_scnt * CNT_EN)) begin
      n_fail++; $display("FAIL parity_cnt: got %0d exp %0d", single_cnt_o, m_scnt * CNT_EN);
    end
    idle();
  endtask

  task automatic test_saturation();
    clear_i = 1;
    tick();
    clear_i = 0;
    for (int i = 0; i < 5; i++) begin
      int exp_sat;
      exp_sat = (i + 1 > 3) ? 3 : i + 1;
      data_i = flip(encode({$urandom, $urandom}), $urandom_range(1, 0), $urandom_range(CW, 1));
      valid_i = 1;
      tick();
      n_checks++;
      if (sat_single_cnt !== 2'(exp_sat * CNT_EN) || single_cnt_o !== 16'((i + 1) * CNT_EN)) begin
        n_fail++; $display("FAIL saturate_%0d: sat %0d wide %0d exp %0d %0d", i, sat_single_cnt,
                           single_cnt_o, exp_sat * CNT_EN, (i + 1) * CNT_EN);
      end
    end
    idle();
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] a, b;
    exp_q.delete();
    a = {$urandom, $urandom};
    b = {$urandom, $urandom};
    data_i = encode(a); valid_i = 1; ready_i = 1;
    tick();
    data_i = encode(b); ready_i = 0;
    #1;
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (ready_o !== 1'b0 || valid_o !== 1'b1 || data_o !== a) begin
        n_fail++; $display("FAIL stall_%0d: ready %b valid %b data %h exp 0 1 %h", i, ready_o, valid_o, data_o, a);
      end
      tick();
    end
    ready_i = 1;
    #1;
    n_checks++;
    if (ready_o !== 1'b1 || exp_q.size() != 1 || data_o !== exp_q.pop_front()) begin
      n_fail++; $display("FAIL b2b_first: ready %b data %h exp 1 %h", ready_o, data_o, a);
    end
    tick();
    valid_i = 0;
    n_checks++;
    if (valid_o !== 1'b1 || exp_q.size() != 1 || data_o !== exp_q.pop_front()) begin
      n_fail++; $display("FAIL b2b_second: valid %b data %h exp 1 %h", valid_o, data_o, b);
    end
    tick();
    n_checks++;
    if (valid_o !== 1'b0 || exp_q.size() != 0) begin
      n_fail++; $display("FAIL b2b_drain: valid %b queue %0d exp 0 0", valid_o, exp_q.size());
    end
  endtask

  task automatic test_random();
    logic [83:0] got, exp;
    exp_q.delete();
    for (int n = 0; n < 300; n++) begin
      valid_i = ($urandom_range(3, 0) != 0);
      ready_i = ($urandom_range(3, 0) != 0);
      clear_i = ($urandom_range(15, 0) == 0);
      data_i = corrupt(encode({$urandom, $urandom}));
      #1;
      n_checks++;
      if (ready_o !== (!m_valid || ready_i)) begin
        n_fail++; $display("FAIL rnd_ready_%0d: got %b exp %b", n, ready_o, !m_valid || ready_i);
      end
      if (m_valid && ready_i) begin
        n_checks++;
        if (exp_q.size() == 0 || data_o !== exp_q.pop_front()) begin
          n_fail++; $display("FAIL rnd_sb_%0d: data %h not next expected word", n, data_o);
        end
      end
      tick();
      got = {valid_o, data_o, syndrome_o, single_error_o, parity_error_o, double_error_o, irq_o};
      exp = {m_valid, m_data, m_syn, m_se, m_pe, m_de, m_irq};
      n_checks++;
      if (got !== exp) begin
        n_fail++; $display("FAIL rnd_state_%0d: got %h exp %h", n, got, exp);
      end
      n_checks++;
      if (single_cnt_o !== 16'(m_scnt * CNT_EN) || double_cnt_o !== 16'(m_dcnt * CNT_EN) ||
          sat_single_cnt !== 2'(m_scnt2 * CNT_EN) || sat_double_cnt !== 2'(m_dcnt2 * CNT_EN)) begin
        n_fail++; $display("FAIL rnd_cnt_%0d: got %0d %0d %0d %0d exp %0d %0d %0d %0d", n, single_cnt_o,
                           double_cnt_o, sat_single_cnt, sat_double_cnt, m_scnt * CNT_EN,
                           m_dcnt * CNT_EN, m_scnt2 * CNT_EN, m_dcnt2 * CNT_EN);
      end
    end
    valid_i = 0; ready_i = 1; clear_i = 0;
    #1;
    if (m_valid) begin
      n_checks++;
      if (exp_q.size() == 0 || data_o !== exp_q.pop_front()) begin
        n_fail++; $display("FAIL rnd_sb_last: data %h not next expected word", data_o);
      end
    end
    tick();
    n_checks++;
    if (exp_q.size() != 0 || valid_o !== 1'b0) begin
      n_fail++; $display("FAIL rnd_drain: queue %0d valid %b exp 0 0", exp_q.size(), valid_o);
    end
  endtask

  task automatic test_reset_mid();
    logic [DW-1:0] d;
    data_i = flip(flip(encode({$urandom, $urandom}), 1, 2), 1, 9); valid_i = 1; ready_i = 1;
    tick();
    valid_i = 0; ready_i = 0;
    tick();
    rst_ni = 0;
    #1;
    model_reset();
    n_checks++;
    if ({valid_o, ready_o, irq_o} !== 3'b010 || {single_cnt_o, double_cnt_o, sat_single_cnt, sat_double_cnt} !== '0) begin
      n_fail++; $display("FAIL async_reset: valid/ready/irq %b cnt %0d %0d exp 010 0 0",
                         {valid_o, ready_o, irq_o}, single_cnt_o, double_cnt_o);
    end
    n_checks++;
    if ({data_o, syndrome_o, single_error_o, parity_error_o, double_error_o} !== '0) begin
      n_fail++; $display("FAIL async_reset_out: data %h syn %h exp zero", data_o, syndrome_o);
    end
    data_i = encode({$urandom, $urandom}); valid_i = 1; ready_i = 1;
    tick();
    n_checks++;
    if (valid_o !== 1'b0) begin
      n_fail++; $display("FAIL reset_accept: valid %b exp 0", valid_o);
    end
    rst_ni = 1;
    d = {$urandom, $urandom};
    data_i = encode(d);
    tick();
    valid_i = 0;
    n_checks++;
    if (valid_o !== 1'b1 || data_o !== d || {single_error_o, parity_error_o, double_error_o} !== '0) begin
      n_fail++; $display("FAIL post_reset: valid %b data %h exp 1 %h", valid_o, data_o, d);
    end
    idle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_clean();
    test_single();
    test_double();
    test_parity();
    test_saturation();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
